// File: rtl/tuner_sequencer.sv
// tuner_sequencer: measurement scheduler for the tuner pipeline.
// Each measurement runs capture, then FFT, then a peak scan over the
// magnitude bins. The block owns the single shared RAM port and grants it to
// one requester at a time. It reports the dominant bin once per measurement.
// Optional feature: define TUNER_SEQ_WATCHDOG_EN to add a per-phase watchdog
// that moves a stalled CAPTURE or FFT phase to ERROR and sets a sticky err flag.
module tuner_sequencer #(
  parameter int N_POINTS    = 1024,
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 16,
  parameter int CAP_W       = 10,
  parameter int MIN_MAG     = 64,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              abort,
  output logic              cap_req,
  input  logic              cap_done,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [CAP_W-1:0]  cap_data,
  output logic              fft_start,
  input  logic              fft_done,
  input  logic              fft_we,
  input  logic [ADDR_W-1:0] fft_addr,
  input  logic [DATA_W-1:0] fft_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] fft_rdata,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [DATA_W-1:0] peak_mag,
  output logic              no_signal,
  output logic              result_valid,
  output logic              busy,
  output logic              err
);

  // Scan address one past the last magnitude bin; reaching it marks the drain cycle.
  localparam logic [ADDR_W-1:0] L_HALF    = ADDR_W'(N_POINTS / 2);
  localparam logic [DATA_W-1:0] L_MIN_MAG = DATA_W'(MIN_MAG);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_FFT, S_SCAN, S_REPORT, S_ERROR
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_timeout;

  logic [ADDR_W-1:0]   r_k;
  logic                r_rd_valid;
  logic [ADDR_W-1:0]   r_rd_bin;
  logic [DATA_W-1:0]   r_run_mag;
  logic [ADDR_W-1:0]   r_run_bin;
  logic                w_hit;
  logic [DATA_W-1:0]   w_best_mag;
  logic [ADDR_W-1:0]   w_best_bin;

  logic                r_cap_req;
  logic                r_fft_start;
  logic                r_result_valid;
  logic [ADDR_W-1:0]   r_peak_bin;
  logic [DATA_W-1:0]   r_peak_mag;
  logic                r_no_signal;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decision; abort overrides every other transition.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (run) w_next = S_CAPTURE;
      S_CAPTURE: if (cap_done) w_next = S_FFT;
                 else if (w_timeout) w_next = S_ERROR;
      S_FFT:     if (fft_done) w_next = S_SCAN;
                 else if (w_timeout) w_next = S_ERROR;
      S_SCAN:    if (r_k == L_HALF) w_next = S_REPORT;
      S_REPORT:  w_next = run ? S_CAPTURE : S_IDLE;
      S_ERROR:   w_next = S_ERROR;
      default:   w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

`ifdef TUNER_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;

  // Phase watchdog: restarts on entry to CAPTURE/FFT, counts cycles spent there.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_wd_cnt <= '0;
    else if ((w_next == S_CAPTURE || w_next == S_FFT) && w_next != r_state)
      r_wd_cnt <= '0;
    else if (r_state == S_CAPTURE || r_state == S_FFT)
      r_wd_cnt <= r_wd_cnt + 1'b1;
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)                 r_err <= 1'b0;
    else if (w_next == S_ERROR) r_err <= 1'b1;
  end

  assign w_timeout = (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign err       = r_err;
`else
  // The timeout limit has no effect without the watchdog.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC > 0);
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

  // Candidate replaces the running peak only when strictly greater (ties keep the lower bin).
  assign w_hit      = r_rd_valid && (r_state == S_SCAN) && (mem_rdata > r_run_mag);
  assign w_best_mag = w_hit ? mem_rdata : r_run_mag;
  assign w_best_bin = w_hit ? r_rd_bin  : r_run_bin;

  // Scan address generator and running peak; re-armed whenever outside SCAN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k        <= '0;
      r_rd_valid <= 1'b0;
      r_rd_bin   <= '0;
      r_run_mag  <= '0;
      r_run_bin  <= '0;
    end else if (r_state != S_SCAN) begin
      r_k        <= ADDR_W'(1);
      r_rd_valid <= 1'b0;
      r_rd_bin   <= '0;
      r_run_mag  <= '0;
      r_run_bin  <= ADDR_W'(1);
    end else begin
      r_k        <= r_k + 1'b1;
      r_rd_valid <= (r_k < L_HALF);
      r_rd_bin   <= r_k;
      r_run_mag  <= w_best_mag;
      r_run_bin  <= w_best_bin;
    end
  end

  // Start pulses on the first cycle of CAPTURE/FFT, result pulse during REPORT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cap_req      <= 1'b0;
      r_fft_start    <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_cap_req      <= (w_next == S_CAPTURE) && (r_state != S_CAPTURE);
      r_fft_start    <= (w_next == S_FFT) && (r_state != S_FFT);
      r_result_valid <= (w_next == S_REPORT);
    end
  end

  // Result registers: load only on entry to REPORT, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_peak_bin  <= '0;
      r_peak_mag  <= '0;
      r_no_signal <= 1'b0;
    end else if (w_next == S_REPORT) begin
      r_peak_bin  <= w_best_bin;
      r_peak_mag  <= w_best_mag;
      r_no_signal <= (w_best_mag < L_MIN_MAG);
    end
  end

  // Shared RAM port grant by state; non-granted requesters are dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_CAPTURE: begin
        mem_we    = cap_we;
        mem_addr  = cap_addr;
        mem_wdata = DATA_W'(cap_data);
      end
      S_FFT: begin
        mem_we    = fft_we;
        mem_addr  = fft_addr;
        mem_wdata = fft_wdata;
      end
      S_SCAN:  mem_addr = r_k;
      default: ;
    endcase
  end

  assign fft_rdata    = mem_rdata;
  assign cap_req      = r_cap_req;
  assign fft_start    = r_fft_start;
  assign result_valid = r_result_valid;
  assign peak_bin     = r_peak_bin;
  assign peak_mag     = r_peak_mag;
  assign no_signal    = r_no_signal;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_tuner_sequencer.sv
// Self-checking bench for tuner_sequencer. A behavioural RAM serves the shared
// port; a reference model finds the expected peak directly from the loaded
// image (strict maximum over bins 1..N/2-1, lowest bin wins ties).
module tb_tuner_sequencer;
  localparam int N    = 1024;
  localparam int AW   = 11;
  localparam int DW   = 16;
  localparam int CW   = 10;
  localparam int HALF = N / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0, abort = 1'b0;
  logic          cap_req, cap_done = 1'b0, cap_we = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic [CW-1:0] cap_data = '0;
  logic          fft_start, fft_done = 1'b0, fft_we = 1'b0;
  logic [AW-1:0] fft_addr = '0;
  logic [DW-1:0] fft_wdata = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, fft_rdata;
  logic [AW-1:0] peak_bin;
  logic [DW-1:0] peak_mag;
  logic          no_signal, result_valid, busy, err;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_cap = 0, cnt_fft = 0, cnt_rv = 0;
  int last_bin, last_mag;

  logic [DW-1:0] ram [0:N-1];
  logic [DW-1:0] img [0:N-1];
  logic          load_req = 1'b0;

  tuner_sequencer #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .abort(abort),
    .cap_req(cap_req), .cap_done(cap_done), .cap_we(cap_we),
    .cap_addr(cap_addr), .cap_data(cap_data),
    .fft_start(fft_start), .fft_done(fft_done), .fft_we(fft_we),
    .fft_addr(fft_addr), .fft_wdata(fft_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fft_rdata(fft_rdata),
    .peak_bin(peak_bin), .peak_mag(peak_mag), .no_signal(no_signal),
    .result_valid(result_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency; load_req copies the image in.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) ram[i] <= img[i];
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  // Pulse counters, sampled at the edge that ends each cycle.
  always @(posedge clk) begin
    if (cap_req === 1'b1)      cnt_cap++;
    if (fft_start === 1'b1)    cnt_fft++;
    if (result_valid === 1'b1) cnt_rv++;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic fill(input int val);
    for (int i = 0; i < N; i++) img[i] = DW'(val);
  endtask

  task automatic load_ram;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Reference peak: strict maximum over bins 1..HALF-1, starting at mag 0 / bin 1.
  task automatic ref_peak(output int bin, output int mag);
    bin = 1;
    mag = 0;
    for (int i = 1; i < HALF; i++)
      if (int'(img[i]) > mag) begin
        mag = int'(img[i]);
        bin = i;
      end
  endtask

  // Drives one full measurement; returns at the negedge showing result_valid.
  task automatic run_measurement(input bit from_idle, input bit hold_run,
                                 input int cap_lat, input int fft_lat,
                                 output bit ok, output int scan_lat, output int first_addr);
    ok = 1'b0;
    scan_lat = 0;
    first_addr = -1;
    if (from_idle) begin
      run = 1'b1;
      @(negedge clk);
    end
    if (!hold_run) run = 1'b0;
    repeat (cap_lat - 1) @(negedge clk);
    cap_done = 1'b1;
    @(negedge clk);
    cap_done = 1'b0;
    repeat (fft_lat - 1) @(negedge clk);
    fft_done = 1'b1;
    for (int n = 1; n <= 700; n++) begin
      @(negedge clk);
      fft_done = 1'b0;
      if (n == 1) first_addr = int'(mem_addr);
      if (result_valid === 1'b1) begin
        ok = 1'b1;
        scan_lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cap_req, fft_start, mem_we, mem_addr, mem_wdata, peak_bin, peak_mag,
         no_signal, result_valid, busy, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got we=%b addr=%0d bin=%0d mag=%0d busy=%b err=%b required all 0",
               mem_we, mem_addr, peak_bin, peak_mag, busy, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    bit ok; int lat, fa, eb, em, c0, f0, r0;
    fill(0);
    for (int i = 1; i < HALF; i++) img[i] = 16'd10;
    img[37] = 16'd900;
    load_ram();
    ref_peak(eb, em);
    c0 = cnt_cap; f0 = cnt_fft; r0 = cnt_rv;
    run_measurement(1'b1, 1'b0, 100, 50, ok, lat, fa);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_done: no result_valid within bound"); end
    n_cmp++;
    if (lat != HALF + 1) begin n_bad++; $display("FAIL single_scan_len: got %0d required %0d", lat, HALF + 1); end
    n_cmp++;
    if (fa != 1) begin n_bad++; $display("FAIL single_first_addr: got %0d required 1", fa); end
    n_cmp++;
    if (peak_bin !== eb[AW-1:0]) begin n_bad++; $display("FAIL single_bin: got %0d required %0d", peak_bin, eb); end
    n_cmp++;
    if (peak_mag !== em[DW-1:0]) begin n_bad++; $display("FAIL single_mag: got %0d required %0d", peak_mag, em); end
    n_cmp++;
    if (no_signal !== 1'b0) begin n_bad++; $display("FAIL single_nosig: got %b required 0", no_signal); end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: busy got %b required 0", busy); end
    n_cmp++;
    if ((cnt_cap - c0) != 1 || (cnt_fft - f0) != 1 || (cnt_rv - r0) != 1) begin
      n_bad++;
      $display("FAIL single_pulses: got cap=%0d fft=%0d rv=%0d required 1 each",
               cnt_cap - c0, cnt_fft - f0, cnt_rv - r0);
    end
  endtask

  task automatic test_tie_dc;
    bit ok; int lat, fa;
    fill(0);
    img[0] = 16'd5000; img[20] = 16'd300; img[80] = 16'd300;
    load_ram();
    run_measurement(1'b1, 1'b0, 5, 5, ok, lat, fa);
    n_cmp++;
    if (!ok || peak_bin !== AW'(20) || peak_mag !== DW'(300) || no_signal !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_dc: got bin=%0d mag=%0d nosig=%b required bin=20 mag=300 nosig=0",
               peak_bin, peak_mag, no_signal);
    end
    @(negedge clk);
  endtask

  task automatic test_no_signal;
    bit ok; int lat, fa;
    fill(0);
    for (int i = 0; i < HALF; i++) img[i] = 16'd63;
    load_ram();
    run_measurement(1'b1, 1'b0, 3, 2, ok, lat, fa);
    n_cmp++;
    if (!ok || peak_bin !== AW'(1) || peak_mag !== DW'(63) || no_signal !== 1'b1) begin
      n_bad++;
      $display("FAIL no_signal: got bin=%0d mag=%0d nosig=%b required bin=1 mag=63 nosig=1",
               peak_bin, peak_mag, no_signal);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    bit ok; int lat, fa, eb, em;
    for (int it = 0; it < 4; it++) begin
      fill(0);
      for (int i = 0; i < HALF; i++)
        img[i] = (it % 2 == 1) ? DW'($urandom_range(0, 65535)) : DW'($urandom_range(0, 70));
      load_ram();
      ref_peak(eb, em);
      run_measurement(1'b1, 1'b0, int'($urandom_range(1, 40)), int'($urandom_range(1, 40)), ok, lat, fa);
      n_cmp++;
      if (!ok || peak_bin !== eb[AW-1:0] || peak_mag !== em[DW-1:0] || no_signal !== (em < 64)) begin
        n_bad++;
        $display("FAIL random_%0d: got bin=%0d mag=%0d nosig=%b required bin=%0d mag=%0d nosig=%b",
                 it, peak_bin, peak_mag, no_signal, eb, em, em < 64);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_arbitration;
    logic [AW-1:0] ca, fa;
    logic [CW-1:0] cd;
    logic [DW-1:0] fd;
    bit seen;
    ca = AW'(HALF + int'($urandom_range(0, HALF - 1)));
    fa = AW'(HALF + int'($urandom_range(0, HALF - 1)));
    cd = CW'($urandom);
    fd = DW'($urandom);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    cap_we = 1'b1; cap_addr = ca; cap_data = cd;
    fft_we = 1'b1; fft_addr = fa; fft_wdata = fd;
    #1;
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, ca, DW'(cd)}) begin
      n_bad++;
      $display("FAIL arb_capture_grant: got we=%b addr=%0d data=%0d required we=1 addr=%0d data=%0d",
               mem_we, mem_addr, mem_wdata, ca, cd);
    end
    @(negedge clk);
    cap_we = 1'b0;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0) begin n_bad++; $display("FAIL arb_fft_in_capture: mem_we got %b required 0", mem_we); end
    cap_done = 1'b1;
    @(negedge clk);
    cap_done = 1'b0;
    cap_we = 1'b1;
    #1;
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, fa, fd}) begin
      n_bad++;
      $display("FAIL arb_fft_grant: got we=%b addr=%0d data=%0d required we=1 addr=%0d data=%0d",
               mem_we, mem_addr, mem_wdata, fa, fd);
    end
    n_cmp++;
    if (fft_rdata !== mem_rdata) begin n_bad++; $display("FAIL arb_rdata_fwd: got %h required %h", fft_rdata, mem_rdata); end
    @(negedge clk);
    fft_we = 1'b0;
    cap_done = 1'b1;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0) begin n_bad++; $display("FAIL arb_cap_in_fft: mem_we got %b required 0", mem_we); end
    @(negedge clk);
    cap_done = 1'b0; cap_we = 1'b0; fft_we = 1'b1;
    #1;
    n_cmp++;
    if (mem_we !== 1'b1) begin n_bad++; $display("FAIL arb_stray_cap_done: mem_we got %b required 1 (still FFT)", mem_we); end
    @(negedge clk);
    fft_we = 1'b0;
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    @(negedge clk);
    cap_we = 1'b1; fft_we = 1'b1;
    #1;
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b0, AW'(2), DW'(0)}) begin
      n_bad++;
      $display("FAIL arb_scan: got we=%b addr=%0d data=%0d required we=0 addr=2 data=0",
               mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    cap_we = 1'b0; fft_we = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 700 && !seen; n++) begin
      @(negedge clk);
      if (result_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL arb_done: no result_valid within bound"); end
    @(negedge clk);
  endtask

  task automatic test_continuous;
    bit ok; int lat, fa, eb, em;
    fill(0);
    for (int i = 0; i < HALF; i++) img[i] = DW'($urandom_range(0, 4000));
    load_ram();
    ref_peak(eb, em);
    run_measurement(1'b1, 1'b1, 8, 6, ok, lat, fa);
    n_cmp++;
    if (!ok || peak_bin !== eb[AW-1:0] || peak_mag !== em[DW-1:0]) begin
      n_bad++;
      $display("FAIL cont_first: got bin=%0d mag=%0d required bin=%0d mag=%0d", peak_bin, peak_mag, eb, em);
    end
    @(negedge clk);
    n_cmp++;
    if (cap_req !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL cont_restart: got cap_req=%b busy=%b required 1 1", cap_req, busy);
    end
    fill(0);
    for (int i = 0; i < HALF; i++) img[i] = DW'($urandom_range(0, 4000));
    load_ram();
    ref_peak(eb, em);
    run_measurement(1'b0, 1'b1, 4, 9, ok, lat, fa);
    n_cmp++;
    if (!ok || peak_bin !== eb[AW-1:0] || peak_mag !== em[DW-1:0]) begin
      n_bad++;
      $display("FAIL cont_second: got bin=%0d mag=%0d required bin=%0d mag=%0d", peak_bin, peak_mag, eb, em);
    end
    last_bin = eb;
    last_mag = em;
    run = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_stop: busy got %b required 0", busy); end
  endtask

  task automatic test_abort;
    int r0, c0;
    fill(0);
    for (int i = 0; i < HALF; i++) img[i] = DW'(i % 7);
    img[300] = 16'd12345;
    load_ram();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    cap_done = 1'b1;
    @(negedge clk);
    cap_done = 1'b0;
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    repeat (200) @(negedge clk);
    r0 = cnt_rv;
    run = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle: busy got %b required 0", busy); end
    c0 = cnt_cap;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || cnt_cap != c0) begin
      n_bad++;
      $display("FAIL abort_run_idle: got busy=%b cap_req_pulses=%0d required busy=0 pulses=0", busy, cnt_cap - c0);
    end
    abort = 1'b0;
    run = 1'b0;
    repeat (600) @(negedge clk);
    n_cmp++;
    if (cnt_rv != r0) begin n_bad++; $display("FAIL abort_no_result: got %0d result pulses required 0", cnt_rv - r0); end
    n_cmp++;
    if (peak_bin !== last_bin[AW-1:0] || peak_mag !== last_mag[DW-1:0]) begin
      n_bad++;
      $display("FAIL abort_retain: got bin=%0d mag=%0d required bin=%0d mag=%0d", peak_bin, peak_mag, last_bin, last_mag);
    end
  endtask

  task automatic test_reset_mid;
    int c0, f0, r0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    cap_done = 1'b1;
    @(negedge clk);
    cap_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || {peak_bin, peak_mag, no_signal} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_state: got busy=%b bin=%0d mag=%0d required all 0", busy, peak_bin, peak_mag);
    end
    rst_n = 1'b1;
    c0 = cnt_cap; f0 = cnt_fft; r0 = cnt_rv;
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    repeat (600) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || cnt_cap != c0 || cnt_fft != f0 || cnt_rv != r0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: got busy=%b pulses cap=%0d fft=%0d rv=%0d required 0",
               busy, cnt_cap - c0, cnt_fft - f0, cnt_rv - r0);
    end
  endtask

  task automatic test_watchdog;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (99) @(negedge clk);
`ifdef TUNER_SEQ_WATCHDOG_EN
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_before: got err=%b busy=%b required 0 1", err, busy);
    end
    @(negedge clk);
    cap_we = 1'b1;
    #1;
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_error: got err=%b busy=%b we=%b required 1 1 0", err, busy, mem_we);
    end
    cap_we = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_abort: got busy=%b err=%b required 0 1", busy, err);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL wd_reset: err got %b required 0", err); end
`else
    repeat (200) @(negedge clk);
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL nowd_wait: got err=%b busy=%b required 0 1", err, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL nowd_abort: busy got %b required 0", busy); end
`endif
    @(negedge clk);
  endtask

  initial begin
    fill(0);
    @(negedge clk);
    test_reset();
    load_ram();
    test_single();
    test_tie_dc();
    test_no_signal();
    test_random();
    test_arbitration();
    test_continuous();
    test_abort();
    test_reset_mid();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
